// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame input snapshot and inter-digit guard.
// Optional blinking of selected digits when SEG7_BLINK_EN is defined (adds blink_mask port).
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int GUARD_CYC  = 4,
    parameter int BLINK_DIV  = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] snap_digits_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg, snap_blank_reg;
    logic [3:0]              snap_nib [NUM_DIGITS];
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    tick_reg;
    logic                    slot_end, frame_end, in_guard, blink_off, lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        hex_to_seg = 7'h7F;
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            4'hF: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt_reg == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_reg == IW'(NUM_DIGITS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign snap_nib[gi] = snap_digits_reg[4*gi +: 4];
        end
        if (GUARD_CYC == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt_reg < CW'(GUARD_CYC));
        end
    endgenerate

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0]         frame_cnt_reg;
    logic                  blink_phase_reg;
    logic [NUM_DIGITS-1:0] snap_blink_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            snap_blink_reg  <= '0;
        end else if (frame_end) begin
            snap_blink_reg <= blink_mask;
            if (frame_cnt_reg == BW'(BLINK_DIV - 1)) begin
                frame_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign blink_off = blink_phase_reg & snap_blink_reg[idx_reg];
`else
    assign blink_off = 1'b0;
`endif

    assign lit = !in_guard && !snap_blank_reg[idx_reg] && !blink_off;

    always_comb begin
        cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end
        // seg/dp follow the scanned digit even while its anode is held off
        seg_next = hex_to_seg(snap_nib[idx_reg]);
        dp_next  = ~snap_dp_reg[idx_reg];
        an_next  = '1;
        if (lit) begin
            an_next[idx_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            idx_reg         <= '0;
            snap_digits_reg <= '0;
            snap_dp_reg     <= '0;
            snap_blank_reg  <= '1;
            seg_reg         <= 7'h7F;
            dp_reg          <= 1'b1;
            an_reg          <= '1;
            tick_reg        <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            seg_reg  <= seg_next;
            dp_reg   <= dp_next;
            an_reg   <= an_next;
            tick_reg <= frame_end;
            if (frame_end) begin
                snap_digits_reg <= digits;
                snap_dp_reg     <= dp_in;
                snap_blank_reg  <= blank;
            end
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle scoreboard of expected outputs plus scenario tasks.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GC = 2;
    localparam int BD = 2;
    localparam int FR = ND * SD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits = 16'h0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    blank = 4'h0;
`ifdef SEG7_BLINK_EN
    logic [3:0]    blink_mask = 4'h0;
`endif
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];

    // reference model state (spec-level)
    int         m_k = 0;
    int         m_frames = 0;
    logic [15:0] m_dig = 16'h0;
    logic [3:0] m_dp = 4'h0, m_blank = 4'hF, m_blink = 4'h0;
    logic       m_phase = 1'b0;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYC(GC), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank(blank),
`ifdef SEG7_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] tab(input int v);
        case (v)
            0: tab = 7'b1000000;  1: tab = 7'b1111001;  2: tab = 7'b0100100;  3: tab = 7'b0110000;
            4: tab = 7'b0011001;  5: tab = 7'b0010010;  6: tab = 7'b0000010;  7: tab = 7'b1111000;
            8: tab = 7'b0000000;  9: tab = 7'b0010000; 10: tab = 7'b0001000; 11: tab = 7'b0000011;
           12: tab = 7'b1000110; 13: tab = 7'b0100001; 14: tab = 7'b0000110; default: tab = 7'b0001110;
        endcase
    endfunction

    // inputs change at posedge+1, so at negedge they equal what the next edge samples
    always @(negedge clk) begin
        exp_t e;
        int   pos, slot;
        if (!rst_n) begin
            e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.tick = 1'b0;
            m_k = 0; m_frames = 0; m_dig = 16'h0; m_dp = 4'h0; m_blank = 4'hF;
            m_blink = 4'h0; m_phase = 1'b0;
        end else begin
            pos  = m_k % SD;
            slot = m_k / SD;
            e.seg  = tab(int'(m_dig[4*slot +: 4]));
            e.dp   = ~m_dp[slot];
            e.an   = 4'hF;
            if (pos >= GC && !m_blank[slot] && !(m_phase && m_blink[slot]))
                e.an[slot] = 1'b0;
            e.tick = (m_k == FR - 1);
            if (m_k == FR - 1) begin
                m_dig = digits; m_dp = dp_in; m_blank = blank;
`ifdef SEG7_BLINK_EN
                m_blink = blink_mask;
`endif
                m_frames++;
                if (m_frames == BD) begin
                    m_frames = 0;
                    m_phase = ~m_phase;
                end
            end
            m_k = (m_k + 1) % FR;
        end
        sb_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (seg !== e.seg || dp !== e.dp || an !== e.an || frame_tick !== e.tick) begin
                errors++;
                $display("FAIL scoreboard t=%0t got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b",
                         $time, seg, dp, an, frame_tick, e.seg, e.dp, e.an, e.tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        digits = 16'h4321; blank = 4'h0; dp_in = 4'h0;
        rst_n = 1'b0;
        step(3);
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got seg=%h dp=%b an=%h tick=%b want 7f 1 f 0", seg, dp, an, frame_tick);
        end
        rst_n = 1'b1;
        for (int j = 0; j < FR; j++) begin
            step(1);
            checks++;
            if (an !== 4'hF) begin
                errors++;
                $display("FAIL reset_dark_frame cycle %0d got an=%h want f", j, an);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_scan_order();
        int ticks = 0, n_e = 0, n_7 = 0;
        for (int j = 0; j < 2 * FR; j++) begin
            step(1);
            if (frame_tick === 1'b1) ticks++;
            if (an === 4'hE) n_e++;
            if (an === 4'h7 && seg === 7'b0011001) n_7++;
            if (j == GC) begin
                checks++;
                if (an !== 4'hE || seg !== 7'b1111001) begin
                    errors++;
                    $display("FAIL scan_first_lit got an=%h seg=%b want e 1111001", an, seg);
                end
            end
        end
        checks++;
        if (ticks != 2 || n_e != 12 || n_7 != 12) begin
            errors++;
            $display("FAIL scan_counts got ticks=%0d an_e=%0d an_7=%0d want 2 12 12", ticks, n_e, n_7);
        end
        $display("test_scan_order done");
    endtask

    task automatic test_decode_sweep();
        for (int v = 0; v <= 16; v++) begin
            if (v < 16) digits[3:0] = 4'(v);
            step(GC + 1);
            if (v > 0) begin
                checks++;
                if (seg !== tab(v - 1) || an !== 4'hE) begin
                    errors++;
                    $display("FAIL decode_%0h got seg=%b an=%h want seg=%b an=e", v - 1, seg, an, tab(v - 1));
                end
            end
            step(FR - GC - 1);
        end
        $display("test_decode_sweep done");
    endtask

    task automatic test_tearing();
        digits = 16'h1111;
        step(FR);
        step(12);
        digits = 16'h2222;
        step(15);
        checks++;
        if (seg !== 7'b1111001 || an !== 4'h7) begin
            errors++;
            $display("FAIL tearing_old got seg=%b an=%h want 1111001 7", seg, an);
        end
        step(5);
        step(GC + 1);
        checks++;
        if (seg !== 7'b0100100 || an !== 4'hE) begin
            errors++;
            $display("FAIL tearing_new got seg=%b an=%h want 0100100 e", seg, an);
        end
        step(FR - GC - 1);
        $display("test_tearing done");
    endtask

    task automatic test_blank_dp();
        blank = 4'b0100; dp_in = 4'b0001;
        step(FR);
        for (int j = 0; j < FR; j++) begin
            step(1);
            checks++;
            if (an === 4'b1011 || dp !== (j < SD ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL blank_dp cycle %0d got an=%b dp=%b want an!=1011 dp=%b", j, an, dp, (j < SD ? 1'b0 : 1'b1));
            end
        end
        blank = 4'h0; dp_in = 4'h0;
        step(FR);
        $display("test_blank_dp done");
    endtask

    task automatic test_reset_mid();
        step(13);
        rst_n = 1'b0;
        step(1);
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got seg=%h dp=%b an=%h tick=%b want 7f 1 f 0", seg, dp, an, frame_tick);
        end
        rst_n = 1'b1;
        for (int j = 0; j < FR; j++) begin
            step(1);
            checks++;
            if (an !== 4'hF) begin
                errors++;
                $display("FAIL reset_mid_dark cycle %0d got an=%h want f", j, an);
            end
        end
        step(FR);
        $display("test_reset_mid done");
    endtask

`ifdef SEG7_BLINK_EN
    task automatic blink_frames(input int nf, input logic [63:0] want_e);
        for (int f = 0; f < nf; f++) begin
            int n_e = 0, n_d = 0;
            for (int j = 0; j < FR; j++) begin
                step(1);
                if (an === 4'hE) n_e++;
                if (an === 4'hD) n_d++;
            end
            checks++;
            if (n_e != int'(want_e[8*f +: 8]) || n_d != (f == 0 ? 0 : 6)) begin
                errors++;
                $display("FAIL blink_frame_%0d got lit0=%0d lit1=%0d want %0d %0d",
                         f, n_e, n_d, int'(want_e[8*f +: 8]), (f == 0 ? 0 : 6));
            end
        end
    endtask

    task automatic test_blink();
        logic [63:0] pat;
        blink_mask = 4'b0001;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        pat = {8'd0, 8'd6, 8'd6, 8'd0, 8'd0, 8'd6, 8'd0};
        blink_frames(7, pat);
        step(10);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        pat = {40'd0, 8'd0, 8'd6, 8'd0};
        blink_frames(3, pat);
        $display("test_blink done");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan_order();
        test_decode_sweep();
        test_tearing();
        test_blank_dp();
        test_reset_mid();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
